// File: rtl/spi_sl_sync.sv
// SPI mode-0 responder running on the system clock.
// sclk/cs/mosi are oversampled through 2-FF synchronisers and edge-detected.
module spi_sl_sync #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TX = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  logic sclk_m_q, sclk_s_q, sclk_d_q;
  logic cs_m_q, cs_s_q, cs_d_q;
  logic mosi_m_q, mosi_s_q;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             full_q, full_d;
  logic             miso_q, miso_d;
  logic             rx_valid_q, rx_valid_d;
  logic             under_q, under_d;

  logic rise, fall, cs_fall, cs_rise;
  logic load_go, take;

  assign rise    = sclk_s_q & ~sclk_d_q;
  assign fall    = ~sclk_s_q & sclk_d_q;
  assign cs_fall = ~cs_s_q & cs_d_q;
  assign cs_rise = cs_s_q & ~cs_d_q;

  // The slot frees up in the load cycle, so a new word can be taken
  // in that same cycle while the old one goes to the shifter.
  assign load_go  = (state_q == LOAD) & ~cs_rise;
  assign tx_ready = ~full_q | load_go;
  assign take     = tx_valid & tx_ready;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    under_d    = 1'b0;
    full_d     = full_q;
    buf_d      = buf_q;

    if (take) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end else if (load_go) begin
      full_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        if (load_go) begin
          if (full_q) begin
            tx_sh_d = buf_q;
          end else begin
            tx_sh_d = DEFAULT_TX;
            under_d = 1'b1;
          end
          miso_d  = tx_sh_d[WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_s_q};
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (fall) begin
          if (bit_cnt_q != '0) begin
            tx_sh_d = tx_sh_q << 1;
            miso_d  = tx_sh_q[WIDTH-2];
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Deselect wins over everything except a word completing this cycle.
    if (cs_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_m_q   <= 1'b0;
      sclk_s_q   <= 1'b0;
      sclk_d_q   <= 1'b0;
      cs_m_q     <= 1'b1;
      cs_s_q     <= 1'b1;
      cs_d_q     <= 1'b1;
      mosi_m_q   <= 1'b0;
      mosi_s_q   <= 1'b0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      sclk_m_q   <= sclk;
      sclk_s_q   <= sclk_m_q;
      sclk_d_q   <= sclk_s_q;
      cs_m_q     <= cs;
      cs_s_q     <= cs_m_q;
      cs_d_q     <= cs_s_q;
      mosi_m_q   <= mosi;
      mosi_s_q   <= mosi_m_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      under_q    <= under_d;
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = under_q;
  assign busy        = ~cs_s_q;

endmodule
